// File: rtl/simd_alu_stage.sv
// simd_alu_stage: two-stage SIMD ALU pipeline with valid/ready handshakes.
//
// Lane width comes from funct3_i[1:0]: 2'b01 = 4x16-bit lanes, 2'b10 = 2x32-bit lanes. Any other
// code is illegal. An illegal operation still flows through the pipeline, but it produces
// result 0, sat 0 and illegal 1. funct3_i[2] is not used by this stage.
// op_i selects the operation:
//   00 ADD, wrapping
//   01 SUB, wrapping
//   10 ADDS, signed saturating
//   11 MUL, low half of each lane
//
// Ports:
//   clk_i, rst_i         clock, synchronous active-high reset
//   flush_i              drops every in-flight operation; the offered input is not accepted
//   in_valid_i/in_ready_o, rs1_i, rs2_i, funct3_i, op_i, rd_i   operation input
//   out_valid_o/out_ready_i, result_o, out_rd_o, out_sat_o, out_illegal_o   result output
//   sat_count_o, sat_clr_i   saturating count of delivered saturated results, and its clear
module simd_alu_stage (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        flush_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [63:0] rs1_i,
  input  logic [63:0] rs2_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  op_i,
  input  logic [4:0]  rd_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [63:0] result_o,
  output logic [4:0]  out_rd_o,
  output logic        out_sat_o,
  output logic        out_illegal_o,
  output logic [15:0] sat_count_o,
  input  logic        sat_clr_i
);

  localparam logic [1:0] LwSimd16 = 2'b01;
  localparam logic [1:0] LwSimd32 = 2'b10;
  localparam logic [1:0] OpAdd    = 2'b00;
  localparam logic [1:0] OpSub    = 2'b01;
  localparam logic [1:0] OpAdds   = 2'b10;
  localparam logic [1:0] OpMul    = 2'b11;

  logic          s1_valid_q, s2_valid_q;
  logic          s1_adv, s2_adv, accept, deliver;

  // Stage 1 payload
  logic [63:0]   s1_res_q, res_d;
  logic [127:0]  s1_prod_q, prod_d;
  logic          s1_mul_q, mul_d;
  logic          s1_w32_q, w32_d;
  logic          s1_sat_q, sat_d;
  logic          s1_ill_q, ill_d;
  logic [4:0]    s1_rd_q;

  // Stage 2 payload
  logic [63:0]   s2_result_q, s2_result_d, mul_low;
  logic [4:0]    s2_rd_q;
  logic          s2_sat_q, s2_ill_q;
  logic [15:0]   sat_count_q;

  logic [15:0]   a16, b16;
  logic [16:0]   sum17;
  logic [31:0]   a32, b32;
  logic [32:0]   sum33;

  assign s2_adv     = !s2_valid_q || out_ready_i;
  assign s1_adv     = !s1_valid_q || s2_adv;
  assign in_ready_o = s1_adv;
  assign accept     = in_valid_i && s1_adv && !flush_i;
  assign deliver    = s2_valid_q && out_ready_i;

  // Stage 1: per-lane compute. Multiplies keep the full product here;
  // stage 2 keeps only the low half of each lane.
  always_comb begin
    res_d  = '0;
    prod_d = '0;
    sat_d  = 1'b0;
    a16    = '0;
    b16    = '0;
    sum17  = '0;
    a32    = '0;
    b32    = '0;
    sum33  = '0;
    ill_d  = !(funct3_i[1:0] == LwSimd16 || funct3_i[1:0] == LwSimd32);
    w32_d  = (funct3_i[1:0] == LwSimd32);
    mul_d  = !ill_d && (op_i == OpMul);
    if (w32_d) begin
      for (int i = 0; i < 2; i++) begin
        a32   = rs1_i[32*i +: 32];
        b32   = rs2_i[32*i +: 32];
        sum33 = {a32[31], a32} + {b32[31], b32};
        prod_d[64*i +: 64] = 64'(a32) * 64'(b32);
        unique case (op_i)
          OpAdd: res_d[32*i +: 32] = a32 + b32;
          OpSub: res_d[32*i +: 32] = a32 - b32;
          OpAdds: begin
            // The sign extension bit disagrees with the MSB only on overflow.
            if (sum33[32] != sum33[31]) begin
              res_d[32*i +: 32] = sum33[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
              sat_d = 1'b1;
            end else begin
              res_d[32*i +: 32] = sum33[31:0];
            end
          end
          OpMul: ;
        endcase
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        a16   = rs1_i[16*i +: 16];
        b16   = rs2_i[16*i +: 16];
        sum17 = {a16[15], a16} + {b16[15], b16};
        prod_d[32*i +: 32] = 32'(a16) * 32'(b16);
        unique case (op_i)
          OpAdd: res_d[16*i +: 16] = a16 + b16;
          OpSub: res_d[16*i +: 16] = a16 - b16;
          OpAdds: begin
            if (sum17[16] != sum17[15]) begin
              res_d[16*i +: 16] = sum17[16] ? 16'h8000 : 16'h7FFF;
              sat_d = 1'b1;
            end else begin
              res_d[16*i +: 16] = sum17[15:0];
            end
          end
          OpMul: ;
        endcase
      end
    end
    if (ill_d) begin
      res_d = '0;
      sat_d = 1'b0;
    end
  end

  // Stage 2: pick the low half of each lane product.
  always_comb begin
    mul_low = '0;
    if (s1_w32_q) begin
      for (int i = 0; i < 2; i++) mul_low[32*i +: 32] = s1_prod_q[64*i +: 32];
    end else begin
      for (int i = 0; i < 4; i++) mul_low[16*i +: 16] = s1_prod_q[32*i +: 16];
    end
    s2_result_d = s1_mul_q ? mul_low : s1_res_q;
  end

  // Valid bits and the saturation counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      sat_count_q <= '0;
    end else begin
      if (flush_i) begin
        s1_valid_q <= 1'b0;
        s2_valid_q <= 1'b0;
      end else begin
        if (s1_adv) s1_valid_q <= in_valid_i;
        if (s2_adv) s2_valid_q <= s1_valid_q;
      end
      if (sat_clr_i) begin
        sat_count_q <= '0;
      end else if (deliver && s2_sat_q && !flush_i && sat_count_q != 16'hFFFF) begin
        sat_count_q <= sat_count_q + 16'd1;
      end
    end
  end

  // Payload registers have no reset; they only load when their stage advances.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      s1_res_q  <= res_d;
      s1_prod_q <= prod_d;
      s1_mul_q  <= mul_d;
      s1_w32_q  <= w32_d;
      s1_sat_q  <= sat_d;
      s1_ill_q  <= ill_d;
      s1_rd_q   <= rd_i;
    end
    if (s2_adv && s1_valid_q) begin
      s2_result_q <= s2_result_d;
      s2_rd_q     <= s1_rd_q;
      s2_sat_q    <= s1_sat_q;
      s2_ill_q    <= s1_ill_q;
    end
  end

  assign out_valid_o   = s2_valid_q;
  assign result_o      = s2_result_q;
  assign out_rd_o      = s2_rd_q;
  assign out_sat_o     = s2_sat_q;
  assign out_illegal_o = s2_ill_q;
  assign sat_count_o   = sat_count_q;

  logic unused_sigs;
  assign unused_sigs = ^{funct3_i[2], s1_prod_q[127:112], s1_prod_q[63:48]};

endmodule

// File: tb/tb_simd_alu_stage.sv
module tb_simd_alu_stage;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [63:0] rs1, rs2, result;
  logic [2:0]  funct3;
  logic [1:0]  op;
  logic [4:0]  rd, out_rd;
  logic        out_sat, out_illegal, sat_clr;
  logic [15:0] sat_count;

  always #5 clk = ~clk;

  simd_alu_stage dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .flush_i       (flush),
    .in_valid_i    (in_valid),
    .in_ready_o    (in_ready),
    .rs1_i         (rs1),
    .rs2_i         (rs2),
    .funct3_i      (funct3),
    .op_i          (op),
    .rd_i          (rd),
    .out_valid_o   (out_valid),
    .out_ready_i   (out_ready),
    .result_o      (result),
    .out_rd_o      (out_rd),
    .out_sat_o     (out_sat),
    .out_illegal_o (out_illegal),
    .sat_count_o   (sat_count),
    .sat_clr_i     (sat_clr)
  );

  typedef struct packed {
    logic [63:0] res;
    logic [4:0]  rd;
    logic        sat;
    logic        ill;
  } exp_t;

  int          errors = 0;
  int          checks = 0;
  int unsigned exp_sat = 0;
  exp_t        q[$];

  // Reference: plain integer arithmetic per lane.
  function automatic exp_t model(input logic [63:0] a, input logic [63:0] b,
                                 input logic [2:0] f3, input logic [1:0] o, input logic [4:0] t);
    exp_t e;
    int w;
    logic [63:0] mask, x, y, r;
    longint sx, sy, s, maxv, minv;
    e = '0;
    e.rd = t;
    if (f3[1:0] == 2'b01) w = 16;
    else if (f3[1:0] == 2'b10) w = 32;
    else begin
      e.ill = 1'b1;
      return e;
    end
    mask = (64'd1 << w) - 64'd1;
    maxv = (longint'(1) << (w - 1)) - 1;
    minv = -(longint'(1) << (w - 1));
    for (int l = 0; l < 64 / w; l++) begin
      x  = (a >> (w * l)) & mask;
      y  = (b >> (w * l)) & mask;
      sx = (x >= (64'd1 << (w - 1))) ? longint'(x) - (longint'(1) << w) : longint'(x);
      sy = (y >= (64'd1 << (w - 1))) ? longint'(y) - (longint'(1) << w) : longint'(y);
      case (o)
        2'd0: r = x + y;
        2'd1: r = x - y;
        2'd2: begin
          s = sx + sy;
          if (s > maxv) begin
            s = maxv;
            e.sat = 1'b1;
          end else if (s < minv) begin
            s = minv;
            e.sat = 1'b1;
          end
          r = 64'(s);
        end
        default: r = x * y;
      endcase
      e.res = e.res | ((r & mask) << (w * l));
    end
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [63:0] a, input logic [63:0] b, input logic [2:0] f,
                        input logic [1:0] o, input logic [4:0] t);
    rs1 = a; rs2 = b; funct3 = f; op = o; rd = t;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; sat_clr = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    set_op(64'h1234, 64'h1, 3'b001, 2'd0, 5'd9);
    tick();
    tick();
    checks++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid);
    if (out_valid !== 1'b0) errors++;
    checks++;
    if (sat_count !== 16'h0) begin
      $display("FAIL reset_sat_count: got %h want 0000", sat_count); errors++;
    end
    // Fill the pipeline, then reset mid-flight with an input still offered.
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      $display("FAIL reset_midflight: got valid=%b ready=%b want 0/1", out_valid, in_ready);
      errors++;
    end
    out_ready = 1'b1;
    tick();
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      $display("FAIL reset_discard: got out_valid=%b want 0", out_valid); errors++;
    end
    exp_sat = 0;
    q.delete();
  endtask

  task automatic test_spec_vectors();
    logic [63:0] va [4], vb [4], vr [4];
    logic [2:0]  vf [4];
    logic [1:0]  vo [4];
    logic        vs [4], vi [4];
    va = '{64'h0001_7FFF_FFFF_0010, 64'h0001_7FFF_FFFF_0010, 64'h00000003_FFFFFFFF,
           64'h0001_7FFF_FFFF_0010};
    vb = '{64'h0001_0001_0001_0020, 64'h0001_0001_0001_0020, 64'h00000005_00000002,
           64'h0001_0001_0001_0020};
    vf = '{3'b101, 3'b001, 3'b010, 3'b111};
    vo = '{2'd0, 2'd2, 2'd3, 2'd2};
    vr = '{64'h0002_8000_0000_0030, 64'h0002_7FFF_0000_0030, 64'h0000000F_FFFFFFFE, 64'h0};
    vs = '{1'b0, 1'b1, 1'b0, 1'b0};
    vi = '{1'b0, 1'b0, 1'b0, 1'b1};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      set_op(va[i], vb[i], vf[i], vo[i], 5'(i + 4));
      tick();
      in_valid = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0) begin
        $display("FAIL vec%0d_early: got out_valid=%b want 0", i, out_valid); errors++;
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || result !== vr[i] || out_rd !== 5'(i + 4) || out_sat !== vs[i]
          || out_illegal !== vi[i]) begin
        $display("FAIL vec%0d: got v=%b res=%h rd=%0d sat=%b ill=%b want v=1 res=%h rd=%0d sat=%b ill=%b",
                 i, out_valid, result, out_rd, out_sat, out_illegal, vr[i], i + 4, vs[i], vi[i]);
        errors++;
      end
      if (vs[i]) exp_sat++;
      tick();
      checks++;
      if (sat_count !== 16'(exp_sat) || out_valid !== 1'b0) begin
        $display("FAIL vec%0d_sat_count: got cnt=%h v=%b want cnt=%h v=0", i, sat_count,
                 out_valid, 16'(exp_sat));
        errors++;
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e [3];
    exp_t got;
    logic [63:0] a [3], b [3];
    logic [2:0]  f [3];
    logic [1:0]  o [3];
    int n = 0;
    for (int i = 0; i < 3; i++) begin
      a[i] = {$urandom, $urandom}; b[i] = {$urandom, $urandom};
      f[i] = ($urandom_range(0, 1) == 0) ? 3'b001 : 3'b010;
      o[i] = 2'($urandom_range(0, 3));
      e[i] = model(a[i], b[i], f[i], o[i], 5'(i + 1));
    end
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      set_op(a[i], b[i], f[i], o[i], 5'(i + 1));
      #1;
      checks++;
      if (in_ready !== (i < 2)) begin
        $display("FAIL b2b_in_ready%0d: got %b want %b", i, in_ready, i < 2); errors++;
      end
      if (i < 2) q.push_back(e[i]);
      tick();
    end
    // Third op still offered; consumer stalls two more cycles.
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || result !== e[0].res || out_rd !== 5'd1) begin
        $display("FAIL b2b_hold%0d: got rdy=%b v=%b res=%h rd=%0d want rdy=0 v=1 res=%h rd=1",
                 c, in_ready, out_valid, result, out_rd, e[0].res);
        errors++;
      end
      tick();
    end
    out_ready = 1'b1;
    for (int c = 0; c < 12 && n < 3; c++) begin
      #1;
      if (in_valid && in_ready) q.push_back(e[2]);
      if (out_valid && out_ready) begin
        got = q.pop_front();
        checks++;
        if (result !== got.res || out_rd !== got.rd) begin
          $display("FAIL b2b_order%0d: got res=%h rd=%0d want res=%h rd=%0d", n, result, out_rd,
                   got.res, got.rd);
          errors++;
        end
        if (got.sat && exp_sat < 65535) exp_sat++;
        n++;
      end
      if (in_valid && in_ready) begin
        tick();
        in_valid = 1'b0;
      end else begin
        tick();
      end
    end
    checks++;
    if (n != 3) begin
      $display("FAIL b2b_count: got %0d deliveries want 3", n); errors++;
    end
  endtask

  task automatic test_random();
    exp_t got;
    logic        hold = 1'b0;
    logic [63:0] hres = '0;
    logic [4:0]  hrd = '0;
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      set_op({$urandom, $urandom}, {$urandom, $urandom},
             ($urandom_range(0, 4) == 0) ? 3'($urandom) : {1'($urandom), 2'($urandom_range(1, 2))},
             2'($urandom), 5'($urandom));
      if ($urandom_range(0, 3) == 0) rs1 = {4{16'h7FFF}};
      if ($urandom_range(0, 3) == 0) rs2 = {2{32'h8000_0000}};
      #1;
      checks++;
      if (sat_count !== 16'(exp_sat)) begin
        $display("FAIL rand_sat_count%0d: got %h want %h", c, sat_count, 16'(exp_sat)); errors++;
      end
      if (out_ready) begin
        checks++;
        if (in_ready !== 1'b1) begin
          $display("FAIL rand_in_ready%0d: got %b want 1", c, in_ready); errors++;
        end
      end
      if (hold) begin
        checks++;
        if (out_valid !== 1'b1 || result !== hres || out_rd !== hrd) begin
          $display("FAIL rand_stable%0d: got v=%b res=%h rd=%0d want v=1 res=%h rd=%0d", c,
                   out_valid, result, out_rd, hres, hrd);
          errors++;
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          $display("FAIL rand_extra%0d: got delivery rd=%0d want none", c, out_rd); errors++;
        end else begin
          got = q.pop_front();
          if (result !== got.res || out_rd !== got.rd || out_sat !== got.sat
              || out_illegal !== got.ill) begin
            $display("FAIL rand_data%0d: got res=%h rd=%0d sat=%b ill=%b want res=%h rd=%0d sat=%b ill=%b",
                     c, result, out_rd, out_sat, out_illegal, got.res, got.rd, got.sat, got.ill);
            errors++;
          end
          if (got.sat && exp_sat < 65535) exp_sat++;
        end
      end
      hold = out_valid && !out_ready;
      hres = result;
      hrd  = out_rd;
      if (in_valid && in_ready) q.push_back(model(rs1, rs2, funct3, op, rd));
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 10 && q.size() > 0; c++) begin
      #1;
      if (out_valid) begin
        got = q.pop_front();
        checks++;
        if (result !== got.res || out_rd !== got.rd) begin
          $display("FAIL rand_drain%0d: got res=%h rd=%0d want res=%h rd=%0d", c, result, out_rd,
                   got.res, got.rd);
          errors++;
        end
        if (got.sat && exp_sat < 65535) exp_sat++;
      end
      tick();
    end
    checks++;
    if (q.size() != 0) begin
      $display("FAIL rand_lost: got %0d undelivered want 0", q.size()); errors++;
    end
  endtask

  task automatic test_flush();
    // Two saturating ops in flight, consumer stalled, then flush.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    set_op({4{16'h7FFF}}, {4{16'h0001}}, 3'b001, 2'd2, 5'd7);
    tick();
    rd = 5'd8;
    tick();
    flush = 1'b1;
    rd = 5'd9;
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      $display("FAIL flush_two: got out_valid=%b want 0", out_valid); errors++;
    end
    // One op in stage 1 with stage 2 empty: the op offered during flush must not enter.
    in_valid = 1'b1;
    rd = 5'd10;
    tick();
    flush = 1'b1;
    rd = 5'd11;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++;
      if (out_valid !== 1'b0) begin
        $display("FAIL flush_idle%0d: got out_valid=%b rd=%0d want 0", c, out_valid, out_rd);
        errors++;
      end
      tick();
    end
    checks++;
    if (sat_count !== 16'(exp_sat)) begin
      $display("FAIL flush_sat_count: got %h want %h", sat_count, 16'(exp_sat)); errors++;
    end
  endtask

  task automatic test_sat_count();
    int acc = 0, dlv = 0, cyc = 0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_sat = 0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    set_op({2{32'h7FFF_FFFF}}, {2{32'h0000_0001}}, 3'b010, 2'd2, 5'd3);
    while (cyc < 65600) begin
      #1;
      if (in_valid && in_ready) acc++;
      if (out_valid && out_ready && out_sat) dlv++;
      tick();
      cyc++;
      if (acc == 65536) in_valid = 1'b0;
      if (dlv == 65536) break;
    end
    exp_sat = (dlv > 65535) ? 65535 : dlv;
    checks++;
    if (dlv != 65536 || cyc != 65538) begin
      $display("FAIL sat_stream: got dlv=%0d cycles=%0d want 65536/65538", dlv, cyc); errors++;
    end
    checks++;
    if (sat_count !== 16'(exp_sat)) begin
      $display("FAIL sat_hold: got %h want %h", sat_count, 16'(exp_sat)); errors++;
    end
    // Clear in the same cycle as a saturating delivery.
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    sat_clr = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_sat !== 1'b1) begin
      $display("FAIL sat_clr_setup: got v=%b sat=%b want 1/1", out_valid, out_sat); errors++;
    end
    tick();
    sat_clr = 1'b0;
    exp_sat = 0;
    checks++;
    if (sat_count !== 16'(exp_sat)) begin
      $display("FAIL sat_clr_wins: got %h want %h", sat_count, 16'(exp_sat)); errors++;
    end
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    exp_sat = 1;
    checks++;
    if (sat_count !== 16'(exp_sat)) begin
      $display("FAIL sat_after_clr: got %h want %h", sat_count, 16'(exp_sat)); errors++;
    end
  endtask

  initial begin
    test_reset();
    test_spec_vectors();
    test_back_to_back();
    test_random();
    test_flush();
    test_sat_count();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/simd_alu_stage.md
SIMD_ALU_STAGE -- requirements
Module: simd_alu_stage

Interface
REQ-001 clk  input  1  stage clock; all state updates on rising edge.
REQ-002 rst  input  1  synchronous, active-high reset.
REQ-003 flush  input  1  discard all in-flight operations.
REQ-004 in_valid  input  1  operation offered by operand organizer.
REQ-005 in_ready  output  1  stage accepts offered operation this cycle.
REQ-006 rs1  input  SIMD_DATA_WIDTH (64)  reorganized/masked operand 1.
REQ-007 rs2  input  SIMD_DATA_WIDTH (64)  reorganized/masked operand 2.
REQ-008 funct3  input  FUNCT3_WIDTH (3)  [1:0] lane width (SIMD16 / SIMD32 per shared defines); [2] ignored here.
REQ-009 op  input  2  00 ADD wrap, 01 SUB wrap, 10 ADDS signed saturating, 11 MUL low-half.
REQ-010 rd  input  5  destination tag, carried unchanged.
REQ-011 out_valid  output  1  result available.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 result  output  64  lane-packed result.
REQ-014 out_rd  output  5  tag of result.
REQ-015 out_sat  output  1  any lane saturated (ADDS only).
REQ-016 out_illegal  output  1  funct3[1:0] not SIMD16/SIMD32.
REQ-017 sat_count  output  16  count of delivered results with out_sat=1.
REQ-018 sat_clr  input  1  clear sat_count.

Function
REQ-019 Lanes: SIMD16 = 4x16-bit, lane i = bits [16i+15:16i]; SIMD32 = 2x32-bit; no carries cross lane boundaries.
REQ-020 ADD/SUB: per-lane modulo 2^w; ADDS: per-lane signed add, clamp to 0x7FFF../0x80.., out_sat=1 if any lane clamped.
REQ-021 MUL: per-lane full product computed in stage 1, lower w bits of each lane kept in stage 2; signedness irrelevant to low half.
REQ-022 Illegal width: result=0, out_sat=0, out_illegal=1; operation still flows through pipeline normally.
REQ-023 Two-stage pipeline S1 (compute), S2 (output register); each stage holds a valid bit and payload.
REQ-024 Accept when in_valid && in_ready; fixed latency: out_valid asserted 2 cycles after accept absent stalls.
REQ-025 s2_adv = !s2_valid || out_ready; s1_adv = !s1_valid || s2_adv; in_ready = s1_adv (combinational, no dependency on in_valid).
REQ-026 Stalled stage holds payload and valid stable; result/out_rd/out_sat/out_illegal stable while out_valid && !out_ready.
REQ-027 Full throughput: one accept and one delivery per cycle when out_ready held high; no bubbles inserted.
REQ-028 Ordering preserved; no result dropped or duplicated except by flush/rst.
REQ-029 flush: s1_valid, s2_valid cleared next cycle; input offered in flush cycle not accepted into pipeline; sat_count not affected by flushed ops.
REQ-030 sat_count increments by 1 on out_valid && out_ready && out_sat; holds at 0xFFFF (no wrap).
REQ-031 sat_clr same cycle as increment: clear wins, sat_count=0.
REQ-032 Payload registers need not reset; outputs other than valids/sat_count are don't-care while out_valid=0.

Reset
REQ-033 rst: s1_valid=0, s2_valid=0, out_valid=0, sat_count=0 next edge; in_ready=1 after reset.
REQ-034 rst mid-operation discards all in-flight ops; rst has priority over flush, sat_clr and accepts.

Verification
REQ-035 SIMD16 ADD rs1=0x0001_7FFF_FFFF_0010, rs2=0x0001_0001_0001_0020 -> 2 cycles later result=0x0002_8000_0000_0030, out_sat=0.
REQ-036 Same operands, ADDS -> result=0x0002_7FFF_0000_0030, out_sat=1; on handshake sat_count 0->1.
REQ-037 SIMD32 MUL rs1=0x00000003_FFFFFFFF, rs2=0x00000005_00000002 -> result=0x0000000F_FFFFFFFE.
REQ-038 Back-to-back 3 ops, out_ready=0 for 3 cycles -> in_ready drops after 2 accepted, result held stable; out_ready=1 -> all 3 delivered in order, rd tags 1,2,3.
REQ-039 Two ops in flight, flush=1 one cycle -> out_valid=0 next cycle, neither result delivered, sat_count unchanged.
REQ-040 sat_count=0xFFFF, saturating delivery -> stays 0xFFFF; sat_clr same cycle as delivery -> 0.
